// File: rtl/scs8hd_bist_pkg.sv
// Shared types and sizing for the o41ai built-in self-test controller.
package scs8hd_bist_pkg;

  localparam int unsigned NUM_VEC = 32;
  localparam int unsigned VEC_W   = 5;
  localparam int unsigned ERR_W   = 6;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned ERR_MAX = 32;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    FIN
  } bist_state_e;

  // Stimulus word; the packed order matches the vector index bits.
  typedef struct packed {
    logic b1;
    logic a4;
    logic a3;
    logic a2;
    logic a1;
  } o41ai_vec_t;

endpackage

// File: rtl/scs8hd_o41ai_model.sv
// Golden o41ai function: Y = !(B1 & (A1 | A2 | A3 | A4)).
module scs8hd_o41ai_model (
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic A4,
  input  logic B1,
  output logic Y_EXP
);

  assign Y_EXP = ~(B1 & (A1 | A2 | A3 | A4));

endmodule

// File: rtl/scs8hd_o41ai_bist.sv
// Exhaustive 32-vector self-test of an o41ai cell: drive, settle, sample, count mismatches.
module scs8hd_o41ai_bist
  import scs8hd_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RESETB,
  input  logic             START,
  input  logic             Y_DUT,
  output logic             A1,
  output logic             A2,
  output logic             A3,
  output logic             A4,
  output logic             B1,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [VEC_W-1:0] FAIL_VEC
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

  bist_state_e      state_q,  state_d;
  logic [VEC_W-1:0] idx_q,    idx_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  o41ai_vec_t       stim_q,   stim_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             pass_q,   pass_d;
  logic [ERR_W-1:0] err_q,    err_d;
  logic [VEC_W-1:0] fail_q,   fail_d;
  logic             y_exp;

  scs8hd_o41ai_model u_model (
    .A1    (stim_q.a1),
    .A2    (stim_q.a2),
    .A3    (stim_q.a3),
    .A4    (stim_q.a4),
    .B1    (stim_q.b1),
    .Y_EXP (y_exp)
  );

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      stim_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fail_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      stim_q   <= stim_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    stim_d   = stim_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_d   = fail_q;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d = DRIVE;
          idx_d   = '0;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      DRIVE: begin
        stim_d = o41ai_vec_t'(idx_q);
        if (SETTLE_CYCLES == 0) begin
          state_d = SAMPLE;
        end else begin
          state_d  = SETTLE;
          settle_d = SETTLE_LD;
        end
      end
      SETTLE: begin
        if (settle_q <= CNT_W'(1)) begin
          settle_d = '0;
          state_d  = SAMPLE;
        end else begin
          settle_d = settle_q - CNT_W'(1);
        end
      end
      SAMPLE: begin
        // First mismatch of the run is the one seen while the count is still zero.
        if (Y_DUT != y_exp) begin
          if (err_q != ERR_W'(ERR_MAX)) err_d = err_q + ERR_W'(1);
          if (err_q == '0) fail_d = idx_q;
        end
        if (idx_q == VEC_W'(NUM_VEC - 1)) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + VEC_W'(1);
          state_d = DRIVE;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign {B1, A4, A3, A2, A1} = stim_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign ERR_CNT  = err_q;
  assign FAIL_VEC = fail_q;

endmodule

// File: doc/scs8hd_o41ai_bist.md
SCS8HD_O41AI_BIST -- requirements
Module: scs8hd_o41ai_bist

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: idle cycles between driving a vector and sampling Y_DUT; legal range 0..15.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESETB  input  1  asynchronous, active-low reset.
REQ-004 START  input  1  run request; sampled only in IDLE.
REQ-005 Y_DUT  input  1  output of the o41ai cell under test.
REQ-006 A1, A2, A3, A4, B1  output  1 each  registered stimulus driven into the cell under test.
REQ-007 BUSY  output  1  high from the cycle after START acceptance until DONE.
REQ-008 DONE  output  1  one-cycle pulse at end of run.
REQ-009 PASS  output  1  high when the last completed run had zero mismatches; held until the next START acceptance.
REQ-010 ERR_CNT  output  6  mismatch count of the current or last run, range 0..32.
REQ-011 FAIL_VEC  output  5  index of the first mismatching vector; 0 when there is no mismatch.

Function
REQ-012 The FSM SHALL have states IDLE, DRIVE, SETTLE, SAMPLE and FIN.
REQ-013 IDLE with START=1 SHALL move to DRIVE, clear ERR_CNT, FAIL_VEC and PASS, and set the vector index to 0.
REQ-014 DRIVE SHALL register {B1,A4,A3,A2,A1} = vector index bits [4:0]; it lasts one cycle.
REQ-015 SETTLE SHALL last exactly SETTLE_CYCLES cycles; when SETTLE_CYCLES=0, DRIVE goes directly to SAMPLE.
REQ-016 SAMPLE SHALL compare Y_DUT with expected = NOT(B1 AND (A1 OR A2 OR A3 OR A4)) computed from the driven vector; it lasts one cycle.
REQ-017 On a mismatch, ERR_CNT SHALL increment, saturating at 32.
REQ-018 On the first mismatch of a run, FAIL_VEC SHALL capture the vector index.
REQ-019 After SAMPLE of index 0..30, the index SHALL increment and the FSM return to DRIVE; after SAMPLE of index 31, it SHALL go to FIN.
REQ-020 FIN SHALL assert DONE for one cycle, set PASS = (ERR_CNT==0) including the final sample, and return to IDLE.
REQ-021 Run latency from START acceptance edge to DONE high SHALL be 32*(SETTLE_CYCLES+2)+1 cycles (129 at default).
REQ-022 START while BUSY SHALL be ignored; START held high through FIN SHALL start a new run from the following IDLE cycle.
REQ-023 Stimulus outputs SHALL hold their last value in IDLE and FIN.

Reset
REQ-024 RESETB low SHALL immediately force the IDLE state and set A1..A4, B1, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC and the settle counter to 0, including mid-run.
REQ-025 After RESETB deasserts, no run SHALL start until START is sampled high in IDLE.

Structure
REQ-026 Package scs8hd_bist_pkg SHALL hold the state enum, the constant NUM_VEC=32, and the widths of ERR_CNT and FAIL_VEC.
REQ-027 The golden model SHALL be one combinational sub-module scs8hd_o41ai_model (inputs A1..A4, B1; output Y_EXP), instantiated once.
REQ-028 Vector index, settle counter, error counter and FSM SHALL live in the top module; no other sub-modules.

Verification
REQ-029 Default parameter, ideal cell model on Y_DUT, START pulse -> DONE 129 cycles later, PASS=1, ERR_CNT=0, FAIL_VEC=0.
REQ-030 Y_DUT stuck at 1 -> ERR_CNT=15, FAIL_VEC=17, PASS=0.
REQ-031 Y_DUT stuck at 0 -> ERR_CNT=17, FAIL_VEC=0, PASS=0.
REQ-032 RESETB pulsed low 50 cycles into a run -> all outputs 0 in the same cycle; a new START then completes with PASS=1.
REQ-033 START re-pulsed at cycles 10 and 60 of a run -> ignored; exactly one DONE and ERR_CNT unchanged.
REQ-034 SETTLE_CYCLES=0 with ideal model -> DONE 65 cycles after START acceptance, PASS=1.
